// File: rtl/serializer_right5_pkg.sv
// Shared definitions for the LSB-first word serializer: state encoding,
// default word width and the bit-counter width rule.
package serializer_right5_pkg;

   localparam int DEFAULT_WIDTH = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter must hold 0..width-1; a one-bit word still needs a one-bit counter.
   function automatic int count_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serializer_right5_bit_counter.sv
// Bit position counter for the serializer: synchronous clear, increment,
// and a terminal-count flag at the last bit of a word.
module bit_counter
   import serializer_right5_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clockpulse,
   input  logic clear,
   input  logic inc,
   output logic terminal
);

   localparam int CW = count_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] bit_count;

   // Wraps to zero after the last bit so the count never exceeds WIDTH-1.
   always_ff @(posedge clockpulse) begin
      if (clear) begin
         bit_count <= '0;
      end else if (inc) begin
         bit_count <= terminal ? '0 : bit_count + CW'(1);
      end
   end

   assign terminal = (bit_count == LAST);

endmodule

// File: rtl/serializer_right5.sv
// Parallel-to-serial converter feeding a right-shifting register, LSB first,
// with gapless back-to-back words and a registered word_done pulse.
module serializer_right5
   import serializer_right5_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clockpulse,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             serial_output,
   output logic             shift_active,
   output logic             word_done
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] hold;
   logic             terminal;
   logic             capture;

   bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clockpulse (clockpulse),
      .clear      (clear | capture),
      .inc        (shift_active),
      .terminal   (terminal)
   );

   assign shift_active  = (state == SHIFT);
   assign ready         = (state == IDLE) || terminal;
   assign capture       = ready & load;
   assign serial_output = shift_active & hold[0];

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = SHIFT;
         SHIFT:   if (terminal) state_next = load ? SHIFT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Capture on an accepted load, otherwise shift while a word is in flight.
   always_ff @(posedge clockpulse) begin
      if (clear) begin
         state     <= IDLE;
         hold      <= '0;
         word_done <= 1'b0;
      end else begin
         state     <= state_next;
         word_done <= shift_active & terminal;
         if (capture) begin
            hold <= data_in;
         end else if (shift_active) begin
            hold <= hold >> 1;
         end
      end
   end

endmodule

// File: tb/tb_serializer_right5.sv
// Self-checking bench for serializer_right5: directed scenarios plus a
// randomized run against a queue-based model of the output bit stream.
module tb_serializer_right5;

   localparam int W = 5;

   logic         clockpulse;
   logic         clear;
   logic         load;
   logic [W-1:0] data_in;
   logic         ready;
   logic         serial_output;
   logic         shift_active;
   logic         word_done;
   logic [W-1:0] signal_q;

   int checks;
   int failures;

   serializer_right5 #(.WIDTH(W)) dut (
      .clockpulse    (clockpulse),
      .clear         (clear),
      .load          (load),
      .data_in       (data_in),
      .ready         (ready),
      .serial_output (serial_output),
      .shift_active  (shift_active),
      .word_done     (word_done)
   );

   initial clockpulse = 1'b0;
   always #5 clockpulse = ~clockpulse;

   // Downstream right-shift register fed by the serial stream.
   always_ff @(posedge clockpulse) begin
      signal_q <= {serial_output, signal_q[W-1:1]};
   end

   task automatic next_cycle();
      @(posedge clockpulse);
      @(negedge clockpulse);
   endtask

   task automatic test_reset();
      clear = 1'b1;
      load = 1'b1;
      data_in = 5'b10101;
      next_cycle();
      next_cycle();
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_ready: got %b expected 1", ready);
      end
      checks++;
      if (serial_output !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_serial: got %b expected 0", serial_output);
      end
      checks++;
      if (shift_active !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_active: got %b expected 0", shift_active);
      end
      checks++;
      if (word_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_done: got %b expected 0", word_done);
      end
      clear = 1'b0;
      load = 1'b0;
      next_cycle();
      checks++;
      if (shift_active !== 1'b0 || ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL post_reset_idle: got active=%b ready=%b expected active=0 ready=1",
                  shift_active, ready);
      end
   endtask

   task automatic test_single_word();
      logic [W-1:0] word;
      word = 5'b10110;
      load = 1'b1;
      data_in = word;
      next_cycle();
      load = 1'b0;
      data_in = '0;
      for (int i = 0; i < W; i++) begin
         checks++;
         if (serial_output !== word[i] || shift_active !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_bit%0d: got serial=%b active=%b expected serial=%b active=1",
                     i, serial_output, shift_active, word[i]);
         end
         checks++;
         if (ready !== (i == W - 1) || word_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_ready%0d: got ready=%b done=%b expected ready=%b done=0",
                     i, ready, word_done, (i == W - 1));
         end
         next_cycle();
      end
      checks++;
      if (word_done !== 1'b1 || shift_active !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_done: got done=%b active=%b expected done=1 active=0",
                  word_done, shift_active);
      end
      checks++;
      if (signal_q !== word) begin
         failures++;
         $display("[TB] FAIL single_downstream: got %b expected %b", signal_q, word);
      end
      next_cycle();
      checks++;
      if (word_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_done_width: got %b expected 0", word_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] stream;
      stream = {5'b11100, 5'b00011};
      load = 1'b1;
      data_in = 5'b00011;
      next_cycle();
      load = 1'b0;
      for (int i = 0; i < 2 * W; i++) begin
         checks++;
         if (serial_output !== stream[i] || shift_active !== 1'b1 || word_done !== (i == W)) begin
            failures++;
            $display("[TB] FAIL b2b_bit%0d: got serial=%b active=%b done=%b expected serial=%b active=1 done=%b",
                     i, serial_output, shift_active, word_done, stream[i], (i == W));
         end
         load = (i == W - 1);
         data_in = (i == W - 1) ? 5'b11100 : 5'b00000;
         next_cycle();
      end
      checks++;
      if (word_done !== 1'b1 || signal_q !== 5'b11100 || shift_active !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_second_done: got done=%b q=%b active=%b expected done=1 q=11100 active=0",
                  word_done, signal_q, shift_active);
      end
      next_cycle();
   endtask

   task automatic test_ignore_load();
      logic [W-1:0] word;
      word = 5'b10110;
      load = 1'b1;
      data_in = word;
      next_cycle();
      load = 1'b0;
      for (int i = 0; i < W; i++) begin
         checks++;
         if (serial_output !== word[i]) begin
            failures++;
            $display("[TB] FAIL ignore_bit%0d: got %b expected %b", i, serial_output, word[i]);
         end
         load = (i == 2);
         data_in = (i == 2) ? 5'b11111 : 5'b00000;
         next_cycle();
      end
      checks++;
      if (shift_active !== 1'b0 || word_done !== 1'b1 || signal_q !== word) begin
         failures++;
         $display("[TB] FAIL ignore_end: got active=%b done=%b q=%b expected active=0 done=1 q=%b",
                  shift_active, word_done, signal_q, word);
      end
      next_cycle();
   endtask

   task automatic test_clear_mid_word();
      load = 1'b1;
      data_in = 5'b01010;
      next_cycle();
      load = 1'b0;
      next_cycle();
      next_cycle();
      next_cycle();
      clear = 1'b1;
      next_cycle();
      clear = 1'b0;
      checks++;
      if (shift_active !== 1'b0 || ready !== 1'b1 || serial_output !== 1'b0 || word_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL clear_mid: got active=%b ready=%b serial=%b done=%b expected 0 1 0 0",
                  shift_active, ready, serial_output, word_done);
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         checks++;
         if (word_done !== 1'b0 || shift_active !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_after%0d: got done=%b active=%b expected 0 0",
                     i, word_done, shift_active);
         end
      end
   endtask

   task automatic test_clear_and_load();
      clear = 1'b1;
      load = 1'b1;
      data_in = 5'($urandom);
      next_cycle();
      clear = 1'b0;
      load = 1'b0;
      checks++;
      if (shift_active !== 1'b0 || ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL clear_load_now: got active=%b ready=%b expected 0 1", shift_active, ready);
      end
      next_cycle();
      checks++;
      if (shift_active !== 1'b0 || serial_output !== 1'b0) begin
         failures++;
         $display("[TB] FAIL clear_load_after: got active=%b serial=%b expected 0 0",
                  shift_active, serial_output);
      end
   endtask

   // Model: a queue of bits still to appear on the line, a queue of the words
   // they belong to, and the pending word_done flag.
   task automatic test_random();
      int           bits[$];
      logic [W-1:0] words[$];
      logic [W-1:0] done_word;
      logic [W-1:0] d;
      logic         exp_done;
      logic         exp_active;
      logic         exp_serial;
      logic         exp_ready;
      logic         do_clear;
      logic         do_load;
      clear = 1'b1;
      load = 1'b0;
      next_cycle();
      clear = 1'b0;
      exp_done = 1'b0;
      done_word = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         exp_active = (bits.size() > 0);
         exp_serial = exp_active ? 1'(bits[0]) : 1'b0;
         exp_ready  = (bits.size() <= 1);
         checks++;
         if (serial_output !== exp_serial || shift_active !== exp_active) begin
            failures++;
            $display("[TB] FAIL rand_stream cyc%0d: got serial=%b active=%b expected serial=%b active=%b",
                     cyc, serial_output, shift_active, exp_serial, exp_active);
         end
         checks++;
         if (ready !== exp_ready || word_done !== exp_done) begin
            failures++;
            $display("[TB] FAIL rand_ctrl cyc%0d: got ready=%b done=%b expected ready=%b done=%b",
                     cyc, ready, word_done, exp_ready, exp_done);
         end
         if (exp_done) begin
            checks++;
            if (signal_q !== done_word) begin
               failures++;
               $display("[TB] FAIL rand_downstream cyc%0d: got %b expected %b", cyc, signal_q, done_word);
            end
         end
         do_clear = ($urandom_range(0, 39) == 0);
         do_load  = ($urandom_range(0, 2) != 0);
         d = W'($urandom);
         if (do_clear) begin
            bits.delete();
            words.delete();
            exp_done = 1'b0;
         end else begin
            exp_done = (bits.size() == 1);
            if (exp_done) done_word = words.pop_front();
            if (bits.size() > 0) void'(bits.pop_front());
            if (do_load && exp_ready) begin
               for (int b = 0; b < W; b++) bits.push_back(int'(d[b]));
               words.push_back(d);
            end
         end
         clear = do_clear;
         load = do_load;
         data_in = d;
         next_cycle();
      end
      clear = 1'b0;
      load = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      clear = 1'b1;
      load = 1'b0;
      data_in = '0;
      @(negedge clockpulse);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_ignore_load();
      test_clear_mid_word();
      test_clear_and_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
